// File: rtl/int_action_table.sv
`default_nettype none
// ============================================================================
// Module   : int_action_table
// Purpose  : Runtime-programmable interrupt action table for the layer
//            controller. Latches interrupt requests into a pending set,
//            picks one winner at a time and presents its function ID,
//            3-word payload and command length over a valid/ack handshake.
// Options  : LC_INT_RR_ARB_EN - when defined, arbitration is round-robin
//            (search starts after the last served index); otherwise fixed
//            priority, lowest index wins.
// Ports    : CLK, RESETn (async, active-low)
//            INT_REQ      - per-entry interrupt requests
//            CFG_*        - config write port (payload words 0..2, control 3)
//            ACT_*        - presented action + ACT_ACK from the consumer
//            INT_PENDING  - pending set
//            INT_OVF      - sticky overflow per entry
// Revision : 1.0 - initial release
// ============================================================================
module int_action_table #(
    parameter int LC_INT_DEPTH = 8,
    parameter int IDX_WIDTH    = 3,
    parameter int FUNC_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [LC_INT_DEPTH-1:0]   INT_REQ,
    input  logic                      CFG_WR_EN,
    input  logic [IDX_WIDTH-1:0]      CFG_IDX,
    input  logic [1:0]                CFG_WORD_SEL,
    input  logic [DATA_WIDTH-1:0]     CFG_WDATA,
    output logic                      ACT_VALID,
    output logic [IDX_WIDTH-1:0]      ACT_IDX,
    output logic [FUNC_WIDTH-1:0]     ACT_FUNC_ID,
    output logic [3*DATA_WIDTH-1:0]   ACT_PAYLOAD,
    output logic [1:0]                ACT_CMD_LEN,
    input  logic                      ACT_ACK,
    output logic [LC_INT_DEPTH-1:0]   INT_PENDING,
    output logic [LC_INT_DEPTH-1:0]   INT_OVF
);

    localparam int c_PAYLOAD_W = 3 * DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    state_t state_q;

    // Action table storage
    logic [FUNC_WIDTH-1:0]   func_q    [LC_INT_DEPTH];
    logic [1:0]              len_q     [LC_INT_DEPTH];
    logic [c_PAYLOAD_W-1:0]  payload_q [LC_INT_DEPTH];
    logic [LC_INT_DEPTH-1:0] en_q;

    logic [LC_INT_DEPTH-1:0] pending_q, pending_d;
    logic [LC_INT_DEPTH-1:0] ovf_q, ovf_d;

    logic [LC_INT_DEPTH-1:0] w_ack_clr;
    logic [LC_INT_DEPTH-1:0] w_req_set;
    logic [LC_INT_DEPTH-1:0] w_ctrl_wr;
    logic [IDX_WIDTH-1:0]    w_win_idx;
    logic                    w_cfg_en;
    logic                    w_cfg_unused;

    assign INT_PENDING  = pending_q;
    assign INT_OVF      = ovf_q;
    assign w_cfg_en     = CFG_WDATA[DATA_WIDTH-1];
    // Reserved control-word bits between cmd_len and enable
    assign w_cfg_unused = ^CFG_WDATA[DATA_WIDTH-2:FUNC_WIDTH+2];

    // ------------------------------------------------------------------------
    // Per-entry event decode
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < LC_INT_DEPTH; gi++) begin : g_entry
        assign w_ack_clr[gi] = (state_q == ST_WAIT_ACK) && ACT_ACK &&
                               (ACT_IDX == IDX_WIDTH'(gi));
        assign w_req_set[gi] = INT_REQ[gi] && en_q[gi];
        assign w_ctrl_wr[gi] = CFG_WR_EN && (CFG_WORD_SEL == 2'd3) &&
                               (CFG_IDX == IDX_WIDTH'(gi));
    end

    // Pending / overflow next state. A new request beats a same-edge ack
    // clear; a control write beats both requests and overflow events.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < LC_INT_DEPTH; i++) begin
            if (w_req_set[i] && pending_q[i] && !w_ack_clr[i]) begin
                ovf_d[i] = 1'b1;
            end
            pending_d[i] = (pending_q[i] && !w_ack_clr[i]) || w_req_set[i];
            if (w_ctrl_wr[i]) begin
                ovf_d[i] = 1'b0;
                if (!w_cfg_en) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef LC_INT_RR_ARB_EN
    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic                 w_rr_found;
    int                   w_rr_pos;

    // Search from the pointer upwards, wrapping at LC_INT_DEPTH.
    always_comb begin
        w_win_idx  = '0;
        w_rr_found = 1'b0;
        w_rr_pos   = 0;
        for (int k = 0; k < LC_INT_DEPTH; k++) begin
            w_rr_pos = int'(rr_ptr_q) + k;
            if (w_rr_pos >= LC_INT_DEPTH) begin
                w_rr_pos = w_rr_pos - LC_INT_DEPTH;
            end
            if (!w_rr_found && pending_q[IDX_WIDTH'(w_rr_pos)]) begin
                w_win_idx  = IDX_WIDTH'(w_rr_pos);
                w_rr_found = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest pending index is the last assignment.
    always_comb begin
        w_win_idx = '0;
        for (int i = LC_INT_DEPTH - 1; i >= 0; i--) begin
            if (pending_q[IDX_WIDTH'(i)]) begin
                w_win_idx = IDX_WIDTH'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Config table
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < LC_INT_DEPTH; i++) begin
                func_q[i]    <= '0;
                len_q[i]     <= '0;
                payload_q[i] <= '0;
            end
            en_q <= '0;
        end else if (CFG_WR_EN) begin
            case (CFG_WORD_SEL)
                2'd0: payload_q[CFG_IDX][c_PAYLOAD_W-1 -: DATA_WIDTH]  <= CFG_WDATA;
                2'd1: payload_q[CFG_IDX][2*DATA_WIDTH-1 -: DATA_WIDTH] <= CFG_WDATA;
                2'd2: payload_q[CFG_IDX][DATA_WIDTH-1:0]               <= CFG_WDATA;
                default: begin
                    func_q[CFG_IDX] <= CFG_WDATA[FUNC_WIDTH-1:0];
                    len_q[CFG_IDX]  <= CFG_WDATA[FUNC_WIDTH+1:FUNC_WIDTH];
                    en_q[CFG_IDX]   <= w_cfg_en;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Presentation FSM: ACT_* are captured once in IDLE and then frozen, so
    // table rewrites during WAIT_ACK never disturb the presented action.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            ACT_VALID   <= 1'b0;
            ACT_IDX     <= '0;
            ACT_FUNC_ID <= '0;
            ACT_PAYLOAD <= '0;
            ACT_CMD_LEN <= '0;
`ifdef LC_INT_RR_ARB_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        ACT_VALID   <= 1'b1;
                        ACT_IDX     <= w_win_idx;
                        ACT_FUNC_ID <= func_q[w_win_idx];
                        ACT_PAYLOAD <= payload_q[w_win_idx];
                        ACT_CMD_LEN <= len_q[w_win_idx];
                        state_q     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ACT_ACK) begin
                        ACT_VALID <= 1'b0;
                        state_q   <= ST_IDLE;
`ifdef LC_INT_RR_ARB_EN
                        rr_ptr_q  <= (ACT_IDX == IDX_WIDTH'(LC_INT_DEPTH - 1)) ?
                                     '0 : ACT_IDX + IDX_WIDTH'(1);
`endif
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_action_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_action_table
// Purpose  : Self-checking bench for int_action_table. Stimulus pushes the
//            expected action into a scoreboard queue; a monitor pops and
//            compares whenever the DUT presents a new action, and keeps
//            comparing while the action is held.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_action_table;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic [7:0]  INT_REQ = '0;
    logic        CFG_WR_EN = 1'b0;
    logic [2:0]  CFG_IDX = '0;
    logic [1:0]  CFG_WORD_SEL = '0;
    logic [31:0] CFG_WDATA = '0;
    logic        ACT_VALID;
    logic [2:0]  ACT_IDX;
    logic [3:0]  ACT_FUNC_ID;
    logic [95:0] ACT_PAYLOAD;
    logic [1:0]  ACT_CMD_LEN;
    logic        ACT_ACK = 1'b0;
    logic [7:0]  INT_PENDING;
    logic [7:0]  INT_OVF;

    int checks   = 0;
    int failures = 0;

    int_action_table dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .INT_REQ      (INT_REQ),
        .CFG_WR_EN    (CFG_WR_EN),
        .CFG_IDX      (CFG_IDX),
        .CFG_WORD_SEL (CFG_WORD_SEL),
        .CFG_WDATA    (CFG_WDATA),
        .ACT_VALID    (ACT_VALID),
        .ACT_IDX      (ACT_IDX),
        .ACT_FUNC_ID  (ACT_FUNC_ID),
        .ACT_PAYLOAD  (ACT_PAYLOAD),
        .ACT_CMD_LEN  (ACT_CMD_LEN),
        .ACT_ACK      (ACT_ACK),
        .INT_PENDING  (INT_PENDING),
        .INT_OVF      (INT_OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  func;
        logic [1:0]  len;
        logic [95:0] pay;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_ok    = 1'b0;
    bit   presented = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_act(input logic [2:0] idx, input logic [3:0] func,
                              input logic [1:0] len, input logic [95:0] pay);
        exp_t e;
        e.idx  = idx;
        e.func = func;
        e.len  = len;
        e.pay  = pay;
        exp_q.push_back(e);
    endtask

    // Monitor: pop on each newly presented action, then keep verifying the
    // held values every cycle until the ack is taken.
    always @(negedge CLK) begin
        if (RESETn && ACT_VALID) begin
            if (!presented) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    cur_ok = 1'b0;
                    $display("FAIL unexpected_action actual idx=%0d required no action", ACT_IDX);
                end else begin
                    cur    = exp_q.pop_front();
                    cur_ok = 1'b1;
                end
                presented = 1'b1;
            end
            if (cur_ok) begin
                check("act_idx",     128'(ACT_IDX),     128'(cur.idx));
                check("act_func",    128'(ACT_FUNC_ID), 128'(cur.func));
                check("act_len",     128'(ACT_CMD_LEN), 128'(cur.len));
                check("act_payload", 128'(ACT_PAYLOAD), 128'(cur.pay));
            end
        end
    end

    always @(posedge CLK) begin
        if (ACT_VALID && ACT_ACK) presented = 1'b0;
    end

    task automatic cfg_write(input logic [2:0] idx, input logic [1:0] sel, input logic [31:0] data);
        CFG_WR_EN    = 1'b1;
        CFG_IDX      = idx;
        CFG_WORD_SEL = sel;
        CFG_WDATA    = data;
        @(negedge CLK);
        CFG_WR_EN    = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] mask);
        INT_REQ = mask;
        @(negedge CLK);
        INT_REQ = '0;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (!ACT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!ACT_VALID) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual valid=0 required valid=1", name);
        end else begin
            ACT_ACK = 1'b1;
            @(negedge CLK);
            ACT_ACK = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},   128'(ACT_VALID),   128'(0));
        check({tag, "_idx"},     128'(ACT_IDX),     128'(0));
        check({tag, "_func"},    128'(ACT_FUNC_ID), 128'(0));
        check({tag, "_payload"}, 128'(ACT_PAYLOAD), 128'(0));
        check({tag, "_len"},     128'(ACT_CMD_LEN), 128'(0));
        check({tag, "_pending"}, 128'(INT_PENDING), 128'(0));
        check({tag, "_ovf"},     128'(INT_OVF),     128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // ---------------- Reset state ----------------
        #1 RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        check_outputs_zero("reset");
        RESETn = 1'b1;
        @(negedge CLK);

        // ---------------- Basic action, latency ----------------
        cfg_write(3'd2, 2'd0, 32'h0000AB00);
        cfg_write(3'd2, 2'd3, 32'h80000012);
        expect_act(3'd2, 4'd2, 2'd1, {32'h0000AB00, 64'h0});
        pulse(8'h04);
        check("lat_pending_edge1", 128'(INT_PENDING), 128'(8'h04));
        check("lat_valid_edge1",   128'(ACT_VALID),   128'(0));
        @(negedge CLK);
        check("lat_valid_edge2",   128'(ACT_VALID),   128'(1));
        wait_ack("basic");
        check("basic_pending_clr", 128'(INT_PENDING), 128'(0));
        check("basic_valid_clr",   128'(ACT_VALID),   128'(0));

        // ---------------- Disabled entry ignored ----------------
        pulse(8'h20);
        repeat (4) @(negedge CLK);
        check("dis_pending", 128'(INT_PENDING), 128'(0));
        check("dis_ovf",     128'(INT_OVF),     128'(0));
        check("dis_valid",   128'(ACT_VALID),   128'(0));

        // ---------------- Hold while rewriting presented entry ----------------
        cfg_write(3'd7, 2'd0, 32'h11111111);
        cfg_write(3'd7, 2'd1, 32'h22222222);
        cfg_write(3'd7, 2'd2, 32'h33333333);
        cfg_write(3'd7, 2'd3, 32'h80000037);
        expect_act(3'd7, 4'd7, 2'd3, {32'h11111111, 32'h22222222, 32'h33333333});
        pulse(8'h80);
        @(negedge CLK);
        check("hold_valid", 128'(ACT_VALID), 128'(1));
        cfg_write(3'd7, 2'd0, 32'hDEAD0000);
        cfg_write(3'd7, 2'd1, 32'hDEAD0001);
        cfg_write(3'd7, 2'd2, 32'hDEAD0002);
        cfg_write(3'd7, 2'd3, 32'h80000029);
        repeat (6) @(negedge CLK);
        wait_ack("hold");
        expect_act(3'd7, 4'd9, 2'd2, {32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002});
        pulse(8'h80);
        wait_ack("rewritten");

        // ---------------- Arbitration ----------------
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        cfg_write(3'd1, 2'd3, 32'h80000011);
        cfg_write(3'd3, 2'd3, 32'h80000033);
        cfg_write(3'd6, 2'd2, 32'h00000066);
        cfg_write(3'd6, 2'd3, 32'h80000006);
        expect_act(3'd1, 4'd1, 2'd1, 96'h0);
        expect_act(3'd3, 4'd3, 2'd3, 96'h0);
        pulse(8'h0A);
        wait_ack("arb_pre0");
        wait_ack("arb_pre1");
`ifdef LC_INT_RR_ARB_EN
        expect_act(3'd6, 4'd6, 2'd0, {64'h0, 32'h00000066});
        expect_act(3'd1, 4'd1, 2'd1, 96'h0);
        expect_act(3'd3, 4'd3, 2'd3, 96'h0);
`else
        expect_act(3'd1, 4'd1, 2'd1, 96'h0);
        expect_act(3'd3, 4'd3, 2'd3, 96'h0);
        expect_act(3'd6, 4'd6, 2'd0, {64'h0, 32'h00000066});
`endif
        pulse(8'h4A);
        wait_ack("arb0");
        check("gap_idle", 128'(ACT_VALID), 128'(0));
        @(negedge CLK);
        check("gap_next", 128'(ACT_VALID), 128'(1));
        wait_ack("arb1");
        wait_ack("arb2");
        check("arb_pending_clr", 128'(INT_PENDING), 128'(0));

        // ---------------- Overflow and same-edge request/ack ----------------
        cfg_write(3'd4, 2'd3, 32'h80000014);
        expect_act(3'd4, 4'd4, 2'd1, 96'h0);
        pulse(8'h10);
        @(negedge CLK);
        pulse(8'h10);
        pulse(8'h10);
        check("ovf_set", 128'(INT_OVF), 128'(8'h10));
        cfg_write(3'd4, 2'd3, 32'h80000014);
        check("ovf_clr_by_ctrl", 128'(INT_OVF),     128'(0));
        check("ovf_pending_kept", 128'(INT_PENDING), 128'(8'h10));
        expect_act(3'd4, 4'd4, 2'd1, 96'h0);
        INT_REQ = 8'h10;
        ACT_ACK = 1'b1;
        @(negedge CLK);
        INT_REQ = '0;
        ACT_ACK = 1'b0;
        check("req_ack_pending", 128'(INT_PENDING), 128'(8'h10));
        check("req_ack_no_ovf",  128'(INT_OVF),     128'(0));
        wait_ack("re_present4");
        check("ovf_final_pending", 128'(INT_PENDING), 128'(0));

        // ---------------- Reset mid-handshake ----------------
        cfg_write(3'd5, 2'd1, 32'h12345678);
        cfg_write(3'd5, 2'd3, 32'h8000002A);
        expect_act(3'd5, 4'hA, 2'd2, {32'h0, 32'h12345678, 32'h0});
        pulse(8'h20);
        @(negedge CLK);
        check("mid_valid", 128'(ACT_VALID), 128'(1));
        pulse(8'h20);
        check("mid_ovf", 128'(INT_OVF), 128'(8'h20));
        #2;
        exp_q.delete();
        presented = 1'b0;
        RESETn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(negedge CLK);
        RESETn = 1'b1;
        pulse(8'h24);
        repeat (4) @(negedge CLK);
        check("post_rst_valid",   128'(ACT_VALID),   128'(0));
        check("post_rst_pending", 128'(INT_PENDING), 128'(0));

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
